// File: rtl/ysyx_24110015_lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I size/sign codes, FSM
// state encodings and the access legality check.
package ysyx_24110015_lsu_pkg;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Unsigned variants exist only for loads; there is no SBU/SHU.
  function automatic logic lsu_access_ok(input logic       wen,
                                         input logic [2:0] funct3,
                                         input logic [1:0] off);
    logic legal;
    logic aligned;
    legal   = 1'b0;
    aligned = 1'b0;
    case (funct3)
      LSU_B: begin
        legal   = 1'b1;
        aligned = 1'b1;
      end
      LSU_H: begin
        legal   = 1'b1;
        aligned = ~off[0];
      end
      LSU_W: begin
        legal   = 1'b1;
        aligned = (off == 2'b00);
      end
      LSU_BU: begin
        legal   = ~wen;
        aligned = 1'b1;
      end
      LSU_HU: begin
        legal   = ~wen;
        aligned = ~off[0];
      end
      default: begin
        legal   = 1'b0;
        aligned = 1'b0;
      end
    endcase
    return legal & aligned;
  endfunction

endpackage

// File: rtl/ysyx_24110015_lsu_align.sv
// Byte-lane steering for the 32-bit bus: store data replication and write
// mask on the way out, load extraction and sign/zero extension on the way in.
module ysyx_24110015_lsu_align
  import ysyx_24110015_lsu_pkg::*;
(
  input  logic        wen_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] req_wdata_o,
  output logic [3:0]  req_wmask_o,
  output logic [31:0] load_data_o,
  output logic        ok_o
);

  logic [31:0] shifted;

  assign ok_o = lsu_access_ok(wen_i, funct3_i, off_i);

  always_comb begin
    req_wdata_o = wdata_i;
    req_wmask_o = 4'b0000;
    if (wen_i) begin
      case (funct3_i)
        LSU_B: begin
          req_wdata_o = {4{wdata_i[7:0]}};
          req_wmask_o = 4'b0001 << off_i;
        end
        LSU_H: begin
          req_wdata_o = {2{wdata_i[15:0]}};
          req_wmask_o = 4'b0011 << off_i;
        end
        LSU_W: begin
          req_wdata_o = wdata_i;
          req_wmask_o = 4'b1111;
        end
        default: begin
          req_wdata_o = wdata_i;
          req_wmask_o = 4'b0000;
        end
      endcase
    end
  end

  // Bring the addressed byte/halfword down to bit 0 before extending.
  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    load_data_o = 32'h0;
    case (funct3_i)
      LSU_B:   load_data_o = {{24{shifted[7]}}, shifted[7:0]};
      LSU_H:   load_data_o = {{16{shifted[15]}}, shifted[15:0]};
      LSU_W:   load_data_o = shifted;
      LSU_BU:  load_data_o = {24'h0, shifted[7:0]};
      LSU_HU:  load_data_o = {16'h0, shifted[15:0]};
      default: load_data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/ysyx_24110015_lsu.sv
// Load/store unit: one memory access in flight, IDLE -> REQ -> RESP -> DONE,
// with illegal or misaligned accesses short-circuited to DONE with out_err.
module ysyx_24110015_lsu
  import ysyx_24110015_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  in_wen,
  input  logic [2:0]            in_funct3,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  output logic                  mem_req_wen,
  output logic [DATA_WIDTH-1:0] mem_req_wdata,
  output logic [3:0]            mem_req_wmask,
  input  logic                  mem_resp_valid,
  output logic                  mem_resp_ready,
  input  logic [DATA_WIDTH-1:0] mem_resp_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err
);

  lsu_state_e            state_q;
  logic                  wen_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_wen_q;
  logic [DATA_WIDTH-1:0] req_wdata_q;
  logic [3:0]            req_wmask_q;
  logic [DATA_WIDTH-1:0] out_rdata_q;
  logic                  out_err_q;

  logic                  idle;
  logic                  al_wen;
  logic [2:0]            al_funct3;
  logic [1:0]            al_off;
  logic [31:0]           al_req_wdata;
  logic [3:0]            al_req_wmask;
  logic [31:0]           al_load_data;
  logic                  al_ok;

  assign idle = (state_q == LSU_IDLE);

  // One aligner serves both directions: in IDLE it sees the incoming op so
  // the request can be registered on accept; later it sees the latched op.
  assign al_wen    = idle ? in_wen         : wen_q;
  assign al_funct3 = idle ? in_funct3      : funct3_q;
  assign al_off    = idle ? in_addr[1:0]   : off_q;

  ysyx_24110015_lsu_align u_align (
    .wen_i       (al_wen),
    .funct3_i    (al_funct3),
    .off_i       (al_off),
    .wdata_i     (in_wdata),
    .rdata_i     (mem_resp_rdata),
    .req_wdata_o (al_req_wdata),
    .req_wmask_o (al_req_wmask),
    .load_data_o (al_load_data),
    .ok_o        (al_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LSU_IDLE;
      wen_q       <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      req_addr_q  <= '0;
      req_wen_q   <= 1'b0;
      req_wdata_q <= '0;
      req_wmask_q <= 4'b0000;
      out_rdata_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          if (in_valid) begin
            wen_q       <= in_wen;
            funct3_q    <= in_funct3;
            off_q       <= in_addr[1:0];
            out_rdata_q <= '0;
            if (al_ok) begin
              req_addr_q  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
              req_wen_q   <= in_wen;
              req_wdata_q <= al_req_wdata;
              req_wmask_q <= al_req_wmask;
              out_err_q   <= 1'b0;
              state_q     <= LSU_REQ;
            end else begin
              req_addr_q  <= '0;
              req_wen_q   <= 1'b0;
              req_wdata_q <= '0;
              req_wmask_q <= 4'b0000;
              out_err_q   <= 1'b1;
              state_q     <= LSU_DONE;
            end
          end
        end
        LSU_REQ: begin
          if (mem_req_ready) begin
            state_q <= LSU_RESP;
          end
        end
        LSU_RESP: begin
          // A store's response is only the write acknowledgement.
          if (mem_resp_valid) begin
            out_rdata_q <= wen_q ? '0 : al_load_data;
            state_q     <= LSU_DONE;
          end
        end
        LSU_DONE: begin
          if (out_ready) begin
            state_q <= LSU_IDLE;
          end
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign in_ready       = idle;
  assign mem_req_valid  = (state_q == LSU_REQ);
  assign mem_resp_ready = (state_q == LSU_RESP);
  assign out_valid      = (state_q == LSU_DONE);

  assign mem_req_addr  = req_addr_q;
  assign mem_req_wen   = req_wen_q;
  assign mem_req_wdata = req_wdata_q;
  assign mem_req_wmask = req_wmask_q;
  assign out_rdata     = out_rdata_q;
  assign out_err       = out_err_q;

endmodule

// File: tb/tb_ysyx_24110015_lsu.sv
// Directed and randomized checks of the LSU against a byte-level reference
// model of the access rules.
module tb_ysyx_24110015_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_wen;
  logic [2:0]  in_funct3;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid;
  logic        mem_resp_ready;
  logic [31:0] mem_resp_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic        out_err;

  int n_assert = 0;
  int n_fail   = 0;

  ysyx_24110015_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_wen         (in_wen),
    .in_funct3      (in_funct3),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_req_wen    (mem_req_wen),
    .mem_req_wdata  (mem_req_wdata),
    .mem_req_wmask  (mem_req_wmask),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_ready (mem_resp_ready),
    .mem_resp_rdata (mem_resp_rdata),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_rdata      (out_rdata),
    .out_err        (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: access size in bytes, 0 for an undefined size code.
  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_ok(input logic wen, input logic [2:0] f3, input logic [31:0] addr);
    int sz;
    sz = m_size(f3);
    if (sz == 0) return 1'b0;
    if (f3[2] && (wen || sz == 4)) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rd);
    int sz;
    logic [63:0] msk;
    logic [63:0] v;
    sz  = m_size(f3);
    msk = (64'd1 << (8 * sz)) - 64'd1;
    v   = ({32'h0, rd} >> (8 * (addr % 4))) & msk;
    if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~msk;
    return v[31:0];
  endfunction

  function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] addr);
    logic [3:0] m;
    int off;
    int sz;
    off = int'(addr % 4);
    sz  = m_size(f3);
    for (int i = 0; i < 4; i++) m[i] = (i >= off) && (i < off + sz);
    return m;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] r;
    logic [31:0] b;
    int sz;
    sz = m_size(f3);
    for (int i = 0; i < 4; i++) begin
      b = (wd >> (8 * (i % sz))) & 32'hFF;
      r[8*i +: 8] = b[7:0];
    end
    return r;
  endfunction

  // Drive one op through the DUT with the given bus/WBU stall counts and
  // check every observable cycle against the model.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] wd, input logic wen,
                        input logic [2:0] f3, input logic [31:0] rd,
                        input int rs, input int ps, input int os);
    logic        ok;
    logic [31:0] exp_rdata;
    ok        = m_ok(wen, f3, addr);
    exp_rdata = (ok && !wen) ? m_load(f3, addr, rd) : 32'h0;
    chk("in_ready_idle", {31'h0, in_ready}, 32'h1);
    in_valid  = 1'b1;
    in_addr   = addr;
    in_wdata  = wd;
    in_wen    = wen;
    in_funct3 = f3;
    tick();
    in_valid  = 1'b0;
    in_addr   = $urandom;
    in_wdata  = $urandom;
    in_wen    = 1'($urandom);
    in_funct3 = 3'($urandom);
    if (ok) begin
      for (int i = 0; i <= rs; i++) begin
        chk("req_valid", {31'h0, mem_req_valid}, 32'h1);
        chk("req_addr", mem_req_addr, addr & 32'hFFFF_FFFC);
        chk("req_wen", {31'h0, mem_req_wen}, {31'h0, wen});
        chk("req_wmask", {28'h0, mem_req_wmask}, wen ? {28'h0, m_mask(f3, addr)} : 32'h0);
        if (wen) chk("req_wdata", mem_req_wdata, m_wdata(f3, wd));
        chk("in_ready_req", {31'h0, in_ready}, 32'h0);
        mem_req_ready = (i == rs);
        tick();
      end
      mem_req_ready = 1'b0;
      for (int i = 0; i <= ps; i++) begin
        chk("resp_ready", {31'h0, mem_resp_ready}, 32'h1);
        chk("req_valid_resp", {31'h0, mem_req_valid}, 32'h0);
        chk("out_valid_resp", {31'h0, out_valid}, 32'h0);
        mem_resp_valid = (i == ps);
        mem_resp_rdata = (i == ps) ? rd : $urandom;
        tick();
      end
      mem_resp_valid = 1'b0;
      mem_resp_rdata = $urandom;
    end else begin
      chk("req_valid_err", {31'h0, mem_req_valid}, 32'h0);
    end
    for (int i = 0; i <= os; i++) begin
      chk("out_valid", {31'h0, out_valid}, 32'h1);
      chk("out_rdata", out_rdata, exp_rdata);
      chk("out_err", {31'h0, out_err}, {31'h0, ~ok});
      chk("in_ready_done", {31'h0, in_ready}, 32'h0);
      chk("req_valid_done", {31'h0, mem_req_valid}, 32'h0);
      out_ready = (i == os);
      tick();
    end
    out_ready = 1'b0;
    chk("in_ready_back", {31'h0, in_ready}, 32'h1);
    chk("out_valid_back", {31'h0, out_valid}, 32'h0);
    $display("op addr=%h f3=%03b wen=%0b wdata=%h rdata=%h stalls=%0d/%0d/%0d -> out=%h err=%0b",
             addr, f3, wen, wd, rd, rs, ps, os, exp_rdata, ~ok);
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_addr        = 32'h0;
    in_wdata       = 32'h0;
    in_wen         = 1'b0;
    in_funct3      = 3'b000;
    mem_req_ready  = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_rdata = 32'h0;
    out_ready      = 1'b0;
    tick();
    tick();
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_req_valid", {31'h0, mem_req_valid}, 32'h0);
    chk("rst_resp_ready", {31'h0, mem_resp_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_req_addr", mem_req_addr, 32'h0);
    chk("rst_req_wmask", {28'h0, mem_req_wmask}, 32'h0);
    chk("rst_req_wdata", mem_req_wdata, 32'h0);
    chk("rst_out_rdata", out_rdata, 32'h0);
    chk("rst_out_err", {31'h0, out_err}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op(32'h8000_0004, 32'hDEAD_BEEF, 1'b1, 3'b010, 32'h0, 0, 0, 0);
    run_op(32'h8000_0003, 32'h0000_00A5, 1'b1, 3'b000, 32'h0, 0, 0, 0);
    run_op(32'h8000_0002, 32'h0, 1'b0, 3'b000, 32'h12F4_5678, 0, 0, 0);
    run_op(32'h8000_0002, 32'h0, 1'b0, 3'b100, 32'h12F4_5678, 0, 0, 0);
    run_op(32'h8000_0002, 32'h0, 1'b0, 3'b001, 32'h12F4_5678, 0, 0, 0);
    run_op(32'h8000_0001, 32'h0, 1'b0, 3'b010, 32'h0, 0, 0, 0);
    run_op(32'h8000_0000, 32'h0, 1'b0, 3'b011, 32'h0, 0, 0, 0);
    run_op(32'h8000_0002, 32'h1234_ABCD, 1'b1, 3'b001, 32'h0, 1, 0, 0);
    run_op(32'h8000_0008, 32'h0, 1'b0, 3'b010, 32'hCAFE_F00D, 3, 2, 2);

    // Abort an access while the bus response is outstanding.
    in_valid  = 1'b1;
    in_addr   = 32'h8000_0010;
    in_wen    = 1'b0;
    in_funct3 = 3'b010;
    tick();
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("abort_in_resp", {31'h0, mem_resp_ready}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
    chk("abort_resp_ready", {31'h0, mem_resp_ready}, 32'h0);
    chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
    chk("abort_out_rdata", out_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_resp_valid = 1'b1;
      mem_resp_rdata = $urandom;
      tick();
      chk("stale_out_valid", {31'h0, out_valid}, 32'h0);
      chk("stale_in_ready", {31'h0, in_ready}, 32'h1);
      chk("stale_req_valid", {31'h0, mem_req_valid}, 32'h0);
    end
    mem_resp_valid = 1'b0;
    $display("op reset-abort in RESP, stale responses ignored");

    for (int n = 0; n < 40; n++) begin
      run_op(32'h8000_0000 | 32'($urandom_range(0, 255)), $urandom, 1'($urandom),
             3'($urandom), $urandom, int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
